irq_ctrl65: RTL

Parametrised interrupt controller that sits between up to 8 peripheral request lines and the 65xx core's irq/nmi inputs. It provides:
- per-source synchronisation;
- edge or level mode per source;
- per-source enable;
- fixed priority;
- a per-source vector low byte substituted during the CPU's IRQ vector fetch.

It replaces the single-wire irq/nmi hookup with a small register-mapped unit on the CPU data bus.

---
 rtl/irq_ctrl65_pkg.sv | 22 ++
 rtl/irq_sync_edge65.sv | 37 +++
 rtl/irq_ctrl65.sv | 138 +++++++++++++
 3 files changed

// File: rtl/irq_ctrl65_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl65_pkg
// Brief    : Shared constants for the 65xx interrupt controller.
// Revision : 1.0
// ============================================================================
package irq_ctrl65_pkg;

    localparam logic [1:0] IRQ_REG_STATUS = 2'd0;
    localparam logic [1:0] IRQ_REG_ENABLE = 2'd1;
    localparam logic [1:0] IRQ_REG_MODE   = 2'd2;
    localparam logic [1:0] IRQ_REG_ACTIVE = 2'd3;

    localparam logic [7:0] IRQ_VEC_DEFAULT = 8'hFE;

    // Each source owns a 2-byte vector slot starting at base.
    function automatic logic [7:0] irq_vec_lo(input logic [7:0] base, input logic [2:0] idx);
        return base + {4'b0000, idx, 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge65.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync_edge65
// Brief    : One request line: synchroniser chain, delayed copy, rising edge.
// Revision : 1.0
// ============================================================================
module irq_sync_edge65 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_src,
    output logic o_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync[0] <= i_src;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_s_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_s    = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_s_d;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl65.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl65
// Brief    : Register-mapped edge/level interrupt controller with vector byte.
// Revision : 1.0
// ============================================================================
module irq_ctrl65
    import irq_ctrl65_pkg::*;
#(
    parameter int         NUM_SRC     = 8,
    parameter int         SYNC_STAGES = 2,
    parameter int         NMI_EN      = 1,
    parameter int         AUTO_ACK    = 1,
    parameter logic [7:0] VEC_BASE    = 8'hE0,
    parameter logic [7:0] VEC_DEFAULT = IRQ_VEC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    input  logic               sel,
    input  logic               wr,
    input  logic [1:0]         addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               irq_o,
    output logic               nmi_o,
    input  logic               vec_rd,
    output logic [7:0]         vec_data
);

    localparam logic [7:0] c_SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);
    localparam logic [7:0] c_REQ_MASK = (NMI_EN != 0) ? (c_SRC_MASK & 8'hFE) : c_SRC_MASK;

    logic [7:0] r_pending;
    logic [7:0] r_enable;
    logic [7:0] r_mode;
    logic [7:0] r_rdata;
    logic       r_irq;
    logic       r_nmi;

    logic [7:0] w_s;
    logic [7:0] w_rise;
    logic [7:0] w_req;
    logic [2:0] w_idx;
    logic       w_valid;
    logic       w_wr;
    logic       w_rd;
    logic       w_ack;
    logic [7:0] w_clr;
    logic [7:0] w_pend_next;
    logic [7:0] w_rd_data;

    // Sources beyond NUM_SRC are tied off so all internal vectors stay 8 bits.
    generate
        for (genvar n = 0; n < 8; n++) begin : g_src
            if (n < NUM_SRC) begin : g_used
                irq_sync_edge65 #(
                    .SYNC_STAGES (SYNC_STAGES)
                ) u_sync (
                    .clk    (clk),
                    .reset  (reset),
                    .i_src  (src[n]),
                    .o_s    (w_s[n]),
                    .o_rise (w_rise[n])
                );
            end else begin : g_unused
                assign w_s[n]    = 1'b0;
                assign w_rise[n] = 1'b0;
            end
        end
    endgenerate

    assign w_req   = r_pending & r_enable & c_REQ_MASK;
    assign w_valid = |w_req;

    always_comb begin
        w_idx = 3'd0;
        for (int n = 7; n >= 0; n--) begin
            if (w_req[n]) begin
                w_idx = 3'(n);
            end
        end
    end

    assign vec_data = w_valid ? irq_vec_lo(VEC_BASE, w_idx) : VEC_DEFAULT;

    assign w_wr  = sel & wr;
    assign w_rd  = sel & ~wr;
    assign w_ack = vec_rd & w_valid & (AUTO_ACK != 0) & r_mode[w_idx];

    assign w_clr = (((w_wr && (addr == IRQ_REG_STATUS)) ? wdata : 8'h00)
                 | (w_ack ? (8'h01 << w_idx) : 8'h00));

    // Edge bits: a new rise beats any clear; level bits simply follow the line.
    assign w_pend_next = c_SRC_MASK & ((r_mode & (w_rise | (r_pending & ~w_clr)))
                                     | (~r_mode & w_s));

    always_comb begin
        w_rd_data = 8'h00;
        case (addr)
            IRQ_REG_STATUS: w_rd_data = r_pending;
            IRQ_REG_ENABLE: w_rd_data = r_enable;
            IRQ_REG_MODE:   w_rd_data = r_mode;
            IRQ_REG_ACTIVE: w_rd_data = {w_valid, 4'b0000, w_idx};
            default:        w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 8'h00;
            r_enable  <= 8'h00;
            r_mode    <= c_SRC_MASK;
            r_rdata   <= 8'h00;
            r_irq     <= 1'b0;
            r_nmi     <= 1'b0;
        end else begin
            r_pending <= w_pend_next;
            if (w_wr && (addr == IRQ_REG_ENABLE)) begin
                r_enable <= wdata & c_SRC_MASK;
            end
            if (w_wr && (addr == IRQ_REG_MODE)) begin
                r_mode <= wdata & c_SRC_MASK;
            end
            if (w_rd) begin
                r_rdata <= w_rd_data;
            end
            r_irq <= w_valid;
            r_nmi <= (NMI_EN != 0) & r_pending[0] & r_enable[0];
        end
    end

    assign rdata = r_rdata;
    assign irq_o = r_irq;
    assign nmi_o = r_nmi;

endmodule
`default_nettype wire
